// File: rtl/post_lna_fetch_sequencer.sv
// Fetch-stage sequencer for the PostLNA DifferentialQBit chain.
// Arbitrates receive (stages 0,1) against transmit (stages 2,3) requests and
// drives one-hot stage enables with a dwell per stage and an all-off guard gap.
`timescale 1ns/1ps

module post_lna_fetch_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_req,
  input  logic        i_tx_req,
  input  logic        i_abort,
  output logic        o_rx_grant,
  output logic        o_tx_grant,
  output logic [3:0]  o_stage_en,
  output logic        o_busy,
  output logic        o_rx_done,
  output logic        o_tx_done,
  output logic        o_abort_ack,
  output logic [15:0] o_op_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STAGE_A = 3'd1,
    GUARD   = 3'd2,
    STAGE_B = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Counters hold the cycles remaining after the current one.
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [3:0] first_stage(input logic tx);
    return tx ? 4'b0100 : 4'b0001;
  endfunction

  function automatic logic [3:0] second_stage(input logic tx);
    return tx ? 4'b1000 : 4'b0010;
  endfunction

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic             r_side, w_next_side;        // 1 = transmit op
  logic             r_last_tx, w_next_last_tx;  // side of the most recent grant
  logic             w_pick_tx;
  logic             r_rx_grant, w_rx_grant;
  logic             r_tx_grant, w_tx_grant;
  logic [3:0]       r_stage_en, w_stage_en;
  logic             r_busy, w_busy;
  logic             r_rx_done, w_rx_done;
  logic             r_tx_done, w_tx_done;
  logic             r_abort_ack, w_abort_ack;
  logic             w_count_inc;
  logic [15:0]      r_op_count;

  // On a tie the side that did not win last time gets the grant.
  assign w_pick_tx = i_tx_req & (~i_rx_req | ~r_last_tx);

  // Next-state and next-output decode; abort overrides every active state.
  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_next_side    = r_side;
    w_next_last_tx = r_last_tx;
    w_rx_grant     = 1'b0;
    w_tx_grant     = 1'b0;
    w_stage_en     = 4'b0000;
    w_busy         = 1'b0;
    w_rx_done      = 1'b0;
    w_tx_done      = 1'b0;
    w_abort_ack    = 1'b0;
    w_count_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rx_req | i_tx_req) begin
          w_next_state   = STAGE_A;
          w_next_cnt     = DWELL_LD;
          w_next_side    = w_pick_tx;
          w_next_last_tx = w_pick_tx;
          w_rx_grant     = ~w_pick_tx;
          w_tx_grant     = w_pick_tx;
          w_stage_en     = first_stage(w_pick_tx);
          w_busy         = 1'b1;
        end
      end
      STAGE_A: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_ZERO) begin
          if (GUARD_CYCLES == 0) begin
            w_next_state = STAGE_B;
            w_next_cnt   = DWELL_LD;
            w_stage_en   = second_stage(r_side);
          end else begin
            w_next_state = GUARD;
            w_next_cnt   = GUARD_LD;
          end
        end else begin
          w_next_cnt = r_cnt - CNT_ONE;
          w_stage_en = first_stage(r_side);
        end
      end
      GUARD: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_ZERO) begin
          w_next_state = STAGE_B;
          w_next_cnt   = DWELL_LD;
          w_stage_en   = second_stage(r_side);
        end else begin
          w_next_cnt = r_cnt - CNT_ONE;
        end
      end
      STAGE_B: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_ZERO) begin
          w_next_state = DONE;
          w_rx_done    = ~r_side;
          w_tx_done    = r_side;
          w_count_inc  = 1'b1;
        end else begin
          w_next_cnt = r_cnt - CNT_ONE;
          w_stage_en = second_stage(r_side);
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    if (i_abort && (r_state != IDLE)) begin
      w_next_state = IDLE;
      w_next_cnt   = CNT_ZERO;
      w_stage_en   = 4'b0000;
      w_busy       = 1'b0;
      w_rx_done    = 1'b0;
      w_tx_done    = 1'b0;
      w_count_inc  = 1'b0;
      w_abort_ack  = 1'b1;
    end
  end

  // State, counters and registered outputs; reset drops stage enables at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= CNT_ZERO;
      r_side      <= 1'b0;
      r_last_tx   <= 1'b1;
      r_rx_grant  <= 1'b0;
      r_tx_grant  <= 1'b0;
      r_stage_en  <= 4'b0000;
      r_busy      <= 1'b0;
      r_rx_done   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_abort_ack <= 1'b0;
      r_op_count  <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_side      <= w_next_side;
      r_last_tx   <= w_next_last_tx;
      r_rx_grant  <= w_rx_grant;
      r_tx_grant  <= w_tx_grant;
      r_stage_en  <= w_stage_en;
      r_busy      <= w_busy;
      r_rx_done   <= w_rx_done;
      r_tx_done   <= w_tx_done;
      r_abort_ack <= w_abort_ack;
      if (w_count_inc) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign o_rx_grant  = r_rx_grant;
  assign o_tx_grant  = r_tx_grant;
  assign o_stage_en  = r_stage_en;
  assign o_busy      = r_busy;
  assign o_rx_done   = r_rx_done;
  assign o_tx_done   = r_tx_done;
  assign o_abort_ack = r_abort_ack;
  assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_post_lna_fetch_sequencer.sv
// Bench for post_lna_fetch_sequencer: two instances (DWELL=4/GUARD=2 and
// DWELL=1/GUARD=0), an operation-level reference model feeding per-instance
// expectation queues, and a monitor comparing every active output cycle.
`timescale 1ns/1ps

module tb_post_lna_fetch_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic        grx;
    logic        gtx;
    logic [3:0]  se;
    logic        busy;
    logic        rxd;
    logic        txd;
    logic        ack;
    logic [15:0] cnt;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rx0 = 1'b0, tx0 = 1'b0, ab0 = 1'b0;
  logic rst1 = 1'b1, rx1 = 1'b0, tx1 = 1'b0, ab1 = 1'b0;
  logic g_rx0, g_tx0, busy0, rxd0, txd0, ack0;
  logic g_rx1, g_tx1, busy1, rxd1, txd1, ack1;
  logic [3:0]  se0, se1;
  logic [15:0] cnt0, cnt1;

  post_lna_fetch_sequencer #(.DWELL_CYCLES(4), .GUARD_CYCLES(2), .CNT_W(8)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_rx_req(rx0), .i_tx_req(tx0), .i_abort(ab0),
    .o_rx_grant(g_rx0), .o_tx_grant(g_tx0), .o_stage_en(se0), .o_busy(busy0),
    .o_rx_done(rxd0), .o_tx_done(txd0), .o_abort_ack(ack0), .o_op_count(cnt0)
  );

  post_lna_fetch_sequencer #(.DWELL_CYCLES(1), .GUARD_CYCLES(0), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_rx_req(rx1), .i_tx_req(tx1), .i_abort(ab1),
    .o_rx_grant(g_rx1), .o_tx_grant(g_tx1), .o_stage_en(se1), .o_busy(busy1),
    .o_rx_done(rxd1), .o_tx_done(txd1), .o_abort_ack(ack1), .o_op_count(cnt1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  frame_t q0[$];
  frame_t q1[$];

  // Operation-level model state: in_op covers grant through the Done cycle,
  // k is the cycle index within the operation.
  logic        m0_in_op = 1'b0, m0_side = 1'b0, m0_last_tx = 1'b1;
  logic        m1_in_op = 1'b0, m1_side = 1'b0, m1_last_tx = 1'b1;
  int          m0_k = 0, m1_k = 0;
  logic [15:0] m0_cnt = 16'd0, m1_cnt = 16'd0;

  // Expected outputs at cycle k of an operation (k=0 is the grant cycle).
  function automatic frame_t frame_at(input int D, input int G, input logic side,
                                      input int k, input logic [15:0] cnt);
    frame_t f;
    f = '0;
    f.cnt  = cnt;
    f.busy = 1'b1;
    if (k == 0) begin
      f.grx = ~side;
      f.gtx = side;
    end
    if (k < D) f.se = side ? 4'b0100 : 4'b0001;
    else if (k < D + G) f.se = 4'b0000;
    else if (k < 2 * D + G) f.se = side ? 4'b1000 : 4'b0010;
    else begin
      f.rxd = ~side;
      f.txd = side;
    end
    return f;
  endfunction

  task automatic model_step(input int D, input int G, input logic rx, input logic tx,
                            input logic ab, inout logic in_op, inout logic side,
                            inout int k, inout logic last_tx, inout logic [15:0] cnt,
                            output frame_t f, output logic pres);
    f = '0;
    pres = 1'b0;
    if (in_op && ab) begin
      in_op = 1'b0;
      f.ack = 1'b1;
      f.cnt = cnt;
      pres = 1'b1;
    end else if (in_op && (k < 2 * D + G)) begin
      k = k + 1;
      if (k == 2 * D + G) cnt = cnt + 16'd1;
      f = frame_at(D, G, side, k, cnt);
      pres = 1'b1;
    end else if (in_op) begin
      in_op = 1'b0;
    end else if (rx || tx) begin
      side = tx && (!rx || !last_tx);
      last_tx = side;
      in_op = 1'b1;
      k = 0;
      f = frame_at(D, G, side, 0, cnt);
      pres = 1'b1;
    end
  endtask

  function automatic logic active(input frame_t a);
    return a.grx | a.gtx | (|a.se) | a.busy | a.rxd | a.txd | a.ack;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cmp_frame(input int id, input frame_t a, input frame_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL frame%0d cyc=%0d got=%h exp=%h", id, cyc, a, e);
    end
  endtask

  // Model: predicts each instance's outputs for the cycle after this edge.
  initial begin
    frame_t f;
    logic p;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst0) begin
        m0_in_op = 1'b0; m0_last_tx = 1'b1; m0_cnt = 16'd0; m0_k = 0;
        q0.delete();
      end else begin
        model_step(4, 2, rx0, tx0, ab0, m0_in_op, m0_side, m0_k, m0_last_tx, m0_cnt, f, p);
        if (p) begin f.cyc = cyc; q0.push_back(f); end
      end
      if (rst1) begin
        m1_in_op = 1'b0; m1_last_tx = 1'b1; m1_cnt = 16'd0; m1_k = 0;
        q1.delete();
      end else begin
        model_step(1, 0, rx1, tx1, ab1, m1_in_op, m1_side, m1_k, m1_last_tx, m1_cnt, f, p);
        if (p) begin f.cyc = cyc; q1.push_back(f); end
      end
    end
  end

  // Monitor: whenever an instance shows activity, pop and compare.
  initial begin
    frame_t a, e;
    forever begin
      @(negedge clk);
      if (!rst0) begin
        a = '0;
        a.cyc = cyc; a.grx = g_rx0; a.gtx = g_tx0; a.se = se0; a.busy = busy0;
        a.rxd = rxd0; a.txd = txd0; a.ack = ack0; a.cnt = cnt0;
        if (active(a)) begin
          if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out0 cyc=%0d got=%h", cyc, a);
          end else begin
            e = q0.pop_front();
            cmp_frame(0, a, e);
          end
        end else if (q0.size() != 0 && int'(q0[0].cyc) <= cyc) begin
          e = q0.pop_front();
          checks++; failures++;
          $display("FAIL missing_out0 cyc=%0d exp=%h", cyc, e);
        end
      end
      if (!rst1) begin
        a = '0;
        a.cyc = cyc; a.grx = g_rx1; a.gtx = g_tx1; a.se = se1; a.busy = busy1;
        a.rxd = rxd1; a.txd = txd1; a.ack = ack1; a.cnt = cnt1;
        if (active(a)) begin
          if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out1 cyc=%0d got=%h", cyc, a);
          end else begin
            e = q1.pop_front();
            cmp_frame(1, a, e);
          end
        end else if (q1.size() != 0 && int'(q1[0].cyc) <= cyc) begin
          e = q1.pop_front();
          checks++; failures++;
          $display("FAIL missing_out1 cyc=%0d exp=%h", cyc, e);
        end
      end
    end
  end

  task automatic set_in(input int id, input logic r, input logic t, input logic a);
    if (id == 0) begin rx0 = r; tx0 = t; ab0 = a; end
    else begin rx1 = r; tx1 = t; ab1 = a; end
  endtask

  function automatic logic got_rx(input int id);
    return (id == 0) ? g_rx0 : g_rx1;
  endfunction

  function automatic logic got_tx(input int id);
    return (id == 0) ? g_tx0 : g_tx1;
  endfunction

  function automatic logic is_busy(input int id);
    return (id == 0) ? busy0 : busy1;
  endfunction

  function automatic logic is_done(input int id);
    return (id == 0) ? (rxd0 | txd0) : (rxd1 | txd1);
  endfunction

  // Raise requests and hold each until its grant; returns first granted side.
  task automatic do_req(input int id, input logic rw, input logic tw, input logic aw,
                        output logic first_tx, output int gcyc);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    first_tx = 1'b0;
    gcyc = -1;
    set_in(id, rw, tw, aw);
    while ((rw || tw) && n < 200) begin
      @(negedge clk);
      n++;
      if (got_rx(id)) begin
        rw = 1'b0;
        if (!got) begin got = 1'b1; first_tx = 1'b0; gcyc = cyc; end
      end
      if (got_tx(id)) begin
        tw = 1'b0;
        if (!got) begin got = 1'b1; first_tx = 1'b1; gcyc = cyc; end
      end
      set_in(id, rw, tw, 1'b0);
    end
    if (rw || tw) begin
      checks++; failures++;
      $display("FAIL req_timeout id=%0d rx=%0b tx=%0b", id, rw, tw);
      set_in(id, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    @(negedge clk);
    while (is_busy(id) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (is_busy(id)) begin
      failures++;
      $display("FAIL idle_timeout id=%0d busy=1 exp=0", id);
    end
  endtask

  task automatic wait_done(input int id, output int dcyc);
    int n;
    n = 0;
    dcyc = -1;
    @(negedge clk);
    while (!is_done(id) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (is_done(id)) dcyc = cyc;
    else begin
      checks++; failures++;
      $display("FAIL done_timeout id=%0d", id);
    end
  endtask

  // Stimulus
  initial begin
    logic ft;
    int g, g2, d;
    repeat (3) @(negedge clk);
    #2;
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk("reset_out0", {g_rx0, g_tx0, se0, busy0, rxd0, txd0, ack0, cnt0}, 32'd0);
    chk("reset_out1", {g_rx1, g_tx1, se1, busy1, rxd1, txd1, ack1, cnt1}, 32'd0);

    // Single one-cycle receive request
    do_req(0, 1'b1, 1'b0, 1'b0, ft, g);
    chk("t1_rx_side", ft, 0);
    wait_done(0, d);
    chk("t1_latency", d - g, 10);
    wait_idle(0);
    chk("t1_count", cnt0, 1);

    // Tie after reset goes to receive, then transmit
    @(negedge clk); #2 rst0 = 1'b1;
    @(negedge clk); #2 rst0 = 1'b0;
    @(negedge clk);
    do_req(0, 1'b1, 1'b1, 1'b0, ft, g);
    chk("t2_first_rx", ft, 0);
    wait_idle(0);
    chk("t2_count", cnt0, 2);

    // Transmit request arriving mid receive op waits for IDLE
    do_req(0, 1'b1, 1'b0, 1'b0, ft, g);
    do_req(0, 1'b0, 1'b1, 1'b0, ft, g2);
    chk("t3_tx_granted", ft, 1);
    chk("t3_tx_after_done", g2 - g, 12);
    wait_idle(0);
    chk("t3_count", cnt0, 4);

    // Abort during GUARD of a transmit op
    do_req(0, 1'b0, 1'b1, 1'b0, ft, g);
    repeat (4) @(negedge clk);
    chk("t4_in_guard", {busy0, se0}, 5'b10000);
    ab0 = 1'b1;
    @(negedge clk);
    ab0 = 1'b0;
    chk("t4_abort_ack", {ack0, busy0, se0, txd0}, 7'b1000000);
    chk("t4_count", cnt0, 4);
    wait_idle(0);

    // Abort in IDLE is ignored; abort with a request lets the request win
    ab0 = 1'b1;
    @(negedge clk);
    ab0 = 1'b0;
    @(negedge clk);
    do_req(0, 1'b1, 1'b0, 1'b1, ft, g);
    chk("abort_req_idle_grant", (g > 0), 1);
    wait_idle(0);

    // Randomized traffic with sporadic aborts
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (g_rx0) rx0 = 1'b0;
      if (g_tx0) tx0 = 1'b0;
      ab0 = ($urandom_range(0, 29) == 0);
      if (!rx0 && $urandom_range(0, 3) == 0) rx0 = 1'b1;
      if (!tx0 && $urandom_range(0, 3) == 0) tx0 = 1'b1;
    end
    set_in(0, 1'b0, 1'b0, 1'b0);
    wait_idle(0);
    wait_idle(0);

    // Operation counter wrap
    @(negedge clk);
    force dut0.r_op_count = 16'hFFFF;
    m0_cnt = 16'hFFFF;
    @(negedge clk);
    release dut0.r_op_count;
    do_req(0, 1'b1, 1'b0, 1'b0, ft, g);
    wait_idle(0);
    chk("t6_wrap", cnt0, 0);

    // No-guard single-dwell instance, then async reset mid STAGE_B
    do_req(1, 1'b1, 1'b0, 1'b0, ft, g);
    wait_done(1, d);
    chk("t5_latency", d - g, 2);
    wait_idle(1);
    do_req(1, 1'b1, 1'b0, 1'b0, ft, g);
    @(negedge clk);
    chk("t5_stage_b", se1, 4'b0010);
    #2 rst1 = 1'b1;
    #1 chk("t5_async_reset", {g_rx1, g_tx1, se1, busy1, rxd1, txd1, ack1, cnt1}, 32'd0);
    @(negedge clk); #2 rst1 = 1'b0;
    @(negedge clk);
    do_req(1, 1'b0, 1'b1, 1'b0, ft, g);
    chk("t5_tx_after_reset", ft, 1);
    wait_idle(1);
    chk("t5_count", cnt1, 1);

    repeat (3) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
